// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the data-memory load/store unit.
package dmem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned LANES  = 4;
  localparam int unsigned CNT_W  = 2;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  // Pick the addressed byte/half out of a storage word and extend it per funct3.
  function automatic logic [WORD_W-1:0] lane_extract(input logic [WORD_W-1:0] word,
                                                     input logic [2:0]        f3,
                                                     input logic [1:0]        off);
    logic [7:0]        b;
    logic [15:0]       h;
    logic [WORD_W-1:0] r;
    b = 8'(word >> {off, 3'b000});
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_W:    r = word;
      F3_BU:   r = {24'd0, b};
      F3_HU:   r = {16'd0, h};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Misalignment or an encoding with no matching load/store instruction.
  function automatic logic access_err(input logic       we,
                                      input logic [2:0] f3,
                                      input logic [1:0] off);
    logic r;
    case (f3)
      F3_B:    r = 1'b0;
      F3_H:    r = off[0];
      F3_W:    r = |off;
      F3_BU:   r = we;
      F3_HU:   r = we | off[0];
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Word-organised RAM with per-byte write enables and a registered, enabled read port.
module dmem_bank
  import dmem_pkg::*;
#(
  parameter int unsigned WADDR_W   = 7,
  parameter              INIT_FILE = ""
) (
  input  logic                clk,
  input  logic [LANES-1:0]    we,
  input  logic                re,
  input  logic [WADDR_W-1:0]  addr,
  input  logic [WORD_W-1:0]   wdata,
  output logic [WORD_W-1:0]   rdata
);

  localparam int unsigned DEPTH = 1 << WADDR_W;

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  // Read data holds between read enables so a multi-cycle load sees a stable word.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (we[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit: handshake FSM, latency counter, alignment checks and load extension.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned READ_LAT  = 1,
  parameter              INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int unsigned WADDR_W = ADDR_W - 2;

  generate
    if (DATA_W != 32) begin : g_bad_data_w
      $error("dmem_lsu: DATA_W must be 32");
    end
    if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_read_lat
      $error("dmem_lsu: READ_LAT must be in 1..4");
    end
  endgenerate

  lsu_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [WORD_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;

  logic              accept_c;
  logic              err_c;
  logic [LANES-1:0]  be_c;
  logic [WORD_W-1:0] wdata_c;
  logic [LANES-1:0]  bank_we_c;
  logic              bank_re_c;
  logic [WORD_W-1:0] bank_rdata;

  assign accept_c = req_valid & req_ready_q;
  assign err_c    = access_err(req_we, req_funct3, req_addr[1:0]);

  // Replicate store data across lanes so the byte enables alone select the target.
  always_comb begin
    be_c    = '0;
    wdata_c = WORD_W'(req_wdata);
    case (req_funct3)
      F3_B: begin
        be_c    = 4'b0001 << req_addr[1:0];
        wdata_c = {4{req_wdata[7:0]}};
      end
      F3_H: begin
        be_c    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{req_wdata[15:0]}};
      end
      F3_W:    be_c = 4'b1111;
      default: be_c = '0;
    endcase
  end

  dmem_bank #(
    .WADDR_W   (WADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_bank (
    .clk   (clk),
    .we    (bank_we_c),
    .re    (bank_re_c),
    .addr  (req_addr[ADDR_W-1:2]),
    .wdata (wdata_c),
    .rdata (bank_rdata)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    f3_d         = f3_q;
    off_d        = off_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    bank_we_c    = '0;
    bank_re_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          f3_d  = req_funct3;
          off_d = req_addr[1:0];
          if (err_c) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else if (req_we) begin
            bank_we_c    = be_c;
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_rdata_d = '0;
          end else begin
            bank_re_c = 1'b1;
            state_d   = WAIT;
            cnt_d     = CNT_W'(READ_LAT - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = lane_extract(bank_rdata, f3_q, off_q);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      f3_q         <= '0;
      off_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      f3_q         <= f3_d;
      off_q        <= off_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = DATA_W'(resp_rdata_q);
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu with one READ_LAT=1 and one READ_LAT=3 instance.
module tb_dmem_lsu;

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        v1, v3;
  logic        req_we;
  logic [2:0]  req_f3;
  logic [8:0]  req_addr;
  logic [31:0] req_wd;
  logic        rdy1, rv1, er1, rdy3, rv3, er3;
  logic [31:0] rd1, rd3;

  int          cur;
  logic        rdy_c, rv_c, er_c;
  logic [31:0] rd_c;

  exp_t sb[$];
  int total;
  int bad;

  dmem_lsu #(.ADDR_W(9), .DATA_W(32), .READ_LAT(1), .INIT_FILE("")) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(rdy1), .req_we(req_we),
    .req_funct3(req_f3), .req_addr(req_addr), .req_wdata(req_wd),
    .resp_valid(rv1), .resp_rdata(rd1), .resp_err(er1));

  dmem_lsu #(.ADDR_W(9), .DATA_W(32), .READ_LAT(3), .INIT_FILE("")) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_ready(rdy3), .req_we(req_we),
    .req_funct3(req_f3), .req_addr(req_addr), .req_wdata(req_wd),
    .resp_valid(rv3), .resp_rdata(rd3), .resp_err(er3));

  always #5 clk = ~clk;

  always_comb begin
    rdy_c = (cur == 3) ? rdy3 : rdy1;
    rv_c  = (cur == 3) ? rv3  : rv1;
    er_c  = (cur == 3) ? er3  : er1;
    rd_c  = (cur == 3) ? rd3  : rd1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One request through the handshake; inputs are scrambled after accept.
  task automatic do_req(input int sel, input logic w, input logic [2:0] f, input logic [8:0] a,
                        input logic [31:0] d, input logic [31:0] ed, input logic ee,
                        input int el, input string nm);
    exp_t e;
    int   n;
    bit   got;
    e.d = ed; e.e = ee; e.lat = el;
    sb.push_back(e);
    cur = sel;
    req_we = w; req_f3 = f; req_addr = a; req_wd = d;
    if (sel == 3) v3 = 1'b1; else v1 = 1'b1;
    #1;
    total++;
    if (rdy_c !== 1'b1) begin
      bad++; $display("FAIL %s ready: got %b want 1", nm, rdy_c);
    end
    @(posedge clk);
    @(negedge clk);
    v1 = 1'b0; v3 = 1'b0;
    req_we = 1'($urandom); req_f3 = 3'($urandom); req_addr = 9'($urandom); req_wd = $urandom;
    n = 1; got = 0;
    while (!got && n <= 8) begin
      if (rv_c === 1'b1) got = 1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    e = sb.pop_front();
    total++;
    if (!got) begin
      bad++; $display("FAIL %s timeout: no resp_valid within 8 cycles", nm);
    end else begin
      if (n != e.lat) begin
        bad++; $display("FAIL %s latency: got %0d want %0d", nm, n, e.lat);
      end
      total++;
      if (rd_c !== e.d) begin
        bad++; $display("FAIL %s rdata: got %h want %h", nm, rd_c, e.d);
      end
      total++;
      if (er_c !== e.e) begin
        bad++; $display("FAIL %s err: got %b want %b", nm, er_c, e.e);
      end
    end
    @(negedge clk);
    total++;
    if (rv_c !== 1'b0) begin
      bad++; $display("FAIL %s pulse: resp_valid still %b", nm, rv_c);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({rdy1, rv1, er1, rdy3, rv3, er3} !== 6'b100100 || rd1 !== 32'd0 || rd3 !== 32'd0) begin
      bad++;
      $display("FAIL reset_state: rdy/rv/er=%b%b%b %b%b%b rd=%h %h want 100 100 0 0",
               rdy1, rv1, er1, rdy3, rv3, er3, rd1, rd3);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (rdy1 !== 1'b1 || rv1 !== 1'b0 || rdy3 !== 1'b1 || rv3 !== 1'b0) begin
      bad++; $display("FAIL reset_release: rdy=%b%b rv=%b%b want 11 00", rdy1, rdy3, rv1, rv3);
    end
  endtask

  task automatic test_extension();
    do_req(1, 1'b1, 3'b010, 9'h010, 32'hDEADBEEF, 32'h0, 1'b0, 1, "sw_10");
    do_req(1, 1'b0, 3'b000, 9'h013, 32'h0, 32'hFFFFFFDE, 1'b0, 2, "lb_13");
    do_req(1, 1'b0, 3'b100, 9'h013, 32'h0, 32'h000000DE, 1'b0, 2, "lbu_13");
    do_req(1, 1'b0, 3'b001, 9'h012, 32'h0, 32'hFFFFDEAD, 1'b0, 2, "lh_12");
    do_req(1, 1'b0, 3'b101, 9'h010, 32'h0, 32'h0000BEEF, 1'b0, 2, "lhu_10");
    do_req(1, 1'b0, 3'b000, 9'h010, 32'h0, 32'hFFFFFFEF, 1'b0, 2, "lb_10");
  endtask

  task automatic test_byte_enable();
    do_req(1, 1'b1, 3'b000, 9'h011, 32'h123456AA, 32'h0, 1'b0, 1, "sb_11");
    do_req(1, 1'b0, 3'b010, 9'h010, 32'h0, 32'hDEADAAEF, 1'b0, 2, "lw_after_sb");
    do_req(1, 1'b1, 3'b001, 9'h012, 32'hFFFF1234, 32'h0, 1'b0, 1, "sh_12");
    do_req(1, 1'b0, 3'b010, 9'h010, 32'h0, 32'h1234AAEF, 1'b0, 2, "lw_after_sh");
  endtask

  task automatic test_errors();
    do_req(1, 1'b0, 3'b010, 9'h012, 32'h0, 32'h0, 1'b1, 1, "lw_mis_12");
    do_req(1, 1'b1, 3'b001, 9'h013, 32'h55555555, 32'h0, 1'b1, 1, "sh_mis_13");
    do_req(1, 1'b0, 3'b011, 9'h010, 32'h0, 32'h0, 1'b1, 1, "ld_f3_011");
    do_req(1, 1'b1, 3'b100, 9'h010, 32'h77777777, 32'h0, 1'b1, 1, "st_f3_100");
    do_req(1, 1'b0, 3'b001, 9'h011, 32'h0, 32'h0, 1'b1, 1, "lh_mis_11");
    do_req(1, 1'b0, 3'b010, 9'h010, 32'h0, 32'h1234AAEF, 1'b0, 2, "lw_unchanged");
  endtask

  task automatic test_latency_window();
    exp_t e;
    do_req(3, 1'b1, 3'b010, 9'h020, 32'h0BADF00D, 32'h0, 1'b0, 1, "sw_20_lat3");
    e.d = 32'h0BADF00D; e.e = 1'b0; e.lat = 4;
    sb.push_back(e);
    cur = 3;
    req_we = 1'b0; req_f3 = 3'b010; req_addr = 9'h020; req_wd = 32'h0;
    v3 = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      req_addr = 9'h010;
      total++;
      if (rdy3 !== 1'b0) begin
        bad++; $display("FAIL window_ready c%0d: got %b want 0", n, rdy3);
      end
      total++;
      if (rv3 !== (n == 4)) begin
        bad++; $display("FAIL window_valid c%0d: got %b want %b", n, rv3, (n == 4));
      end
      if (n == 4) begin
        e = sb.pop_front();
        total++;
        if (rd3 !== e.d || er3 !== e.e) begin
          bad++; $display("FAIL window_data: got %h/%b want %h/%b", rd3, er3, e.d, e.e);
        end
      end
    end
    v3 = 1'b0;
    for (int n = 5; n <= 8; n++) begin
      @(negedge clk);
      total++;
      if (rv3 !== 1'b0 || rdy3 !== 1'b1) begin
        bad++; $display("FAIL window_extra c%0d: rv=%b rdy=%b want 0 1", n, rv3, rdy3);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    cur = 3;
    req_we = 1'b0; req_f3 = 3'b010; req_addr = 9'h020; req_wd = 32'h0;
    v3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v3 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (rdy3 !== 1'b1 || rv3 !== 1'b0) begin
      bad++; $display("FAIL midreset_now: rdy=%b rv=%b want 1 0", rdy3, rv3);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      total++;
      if (rv3 !== 1'b0) begin
        bad++; $display("FAIL midreset_dropped c%0d: resp_valid=%b want 0", n, rv3);
      end
    end
    do_req(3, 1'b0, 3'b010, 9'h020, 32'h0, 32'h0BADF00D, 1'b0, 4, "lw_20_after_rst");
    do_req(1, 1'b0, 3'b010, 9'h010, 32'h0, 32'h1234AAEF, 1'b0, 2, "lw_10_after_rst");
  endtask

  task automatic test_boundary();
    do_req(1, 1'b1, 3'b010, 9'h000, 32'h11223344, 32'h0, 1'b0, 1, "sw_000");
    do_req(1, 1'b1, 3'b010, 9'h1FC, 32'hCAFEBABE, 32'h0, 1'b0, 1, "sw_1fc");
    do_req(1, 1'b0, 3'b100, 9'h1FF, 32'h0, 32'h000000CA, 1'b0, 2, "lbu_1ff");
    do_req(1, 1'b0, 3'b001, 9'h1FE, 32'h0, 32'hFFFFCAFE, 1'b0, 2, "lh_1fe");
    do_req(1, 1'b0, 3'b010, 9'h000, 32'h0, 32'h11223344, 1'b0, 2, "lw_000");
    do_req(3, 1'b1, 3'b010, 9'h1FC, 32'h89ABCDEF, 32'h0, 1'b0, 1, "sw_1fc_lat3");
    do_req(3, 1'b0, 3'b101, 9'h1FE, 32'h0, 32'h000089AB, 1'b0, 4, "lhu_1fe_lat3");
  endtask

  // Random word stores followed by sub-word reloads checked against an independent model.
  task automatic test_random();
    logic [8:0]  a;
    logic [31:0] d, eb, eh;
    logic [1:0]  off;
    logic [15:0] h;
    for (int i = 0; i < 6; i++) begin
      a   = {7'($urandom_range(16, 100)), 2'b00};
      d   = $urandom;
      off = 2'($urandom);
      eb  = (d >> (8 * off)) & 32'hFF;
      h   = off[1] ? d[31:16] : d[15:0];
      eh  = {{16{h[15]}}, h};
      do_req(1, 1'b1, 3'b010, a, d, 32'h0, 1'b0, 1, "rnd_sw");
      do_req(1, 1'b0, 3'b010, a, 32'h0, d, 1'b0, 2, "rnd_lw");
      do_req(1, 1'b0, 3'b100, a | 9'(off), 32'h0, eb, 1'b0, 2, "rnd_lbu");
      do_req(1, 1'b0, 3'b001, a | 9'({off[1], 1'b0}), 32'h0, eh, 1'b0, 2, "rnd_lh");
    end
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0;
    v1 = 1'b0; v3 = 1'b0;
    req_we = 1'b0; req_f3 = 3'b000; req_addr = '0; req_wd = '0;
    cur = 1; total = 0; bad = 0;
    test_reset();
    test_extension();
    test_byte_enable();
    test_errors();
    test_latency_window();
    test_reset_mid_load();
    test_boundary();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
